// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: pipelined unsigned adder tree, one register level per tree level, with stall and valid
module adder_tree_pipe #(
    parameter int N          = 10,
    parameter int NUM_INPUTS = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall,
    input  logic                               in_valid,
    input  logic [NUM_INPUTS*N-1:0]            in_data,
    output logic                               out_valid,
    output logic [N+$clog2(NUM_INPUTS)-1:0]    out_sum
);
    localparam int LEVELS = $clog2(NUM_INPUTS);
    genvar l;
    generate
        for (l = 1; l <= LEVELS; l++) begin : lv
            localparam int M = NUM_INPUTS >> l;
            logic                  pv;
            logic                  v;
            logic [2*M-1:0][N+l-2:0] a;
            logic [M-1:0][N+l-1:0]   s;
            if (l == 1) begin : src
                assign pv = in_valid;
                assign a  = in_data;
            end else begin : src
                assign pv = lv[l-1].v;
                assign a  = lv[l-1].s;
            end
            always_ff @(posedge clk) begin
                if (reset) begin
                    v <= 1'b0;
                    s <= '0;
                end else if (!stall) begin
                    v <= pv;
                    if (pv)
                        for (int k = 0; k < M; k++)
                            s[k] <= {1'b0, a[2*k]} + {1'b0, a[2*k+1]};
                end
            end
        end
    endgenerate
    assign out_valid = lv[LEVELS].v;
    assign out_sum   = lv[LEVELS].s[0];
endmodule

// File: tb/tb_adder_tree_pipe.sv
// tb_adder_tree_pipe: directed and random checks of adder_tree_pipe against a beat-queue model
module tb_adder_tree_pipe;
    localparam int N  = 10;
    localparam int NI = 8;
    localparam int LV = 3;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall = 1'b0;
    logic in_valid = 1'b0;
    logic [NI*N-1:0] in_data = '0;
    logic out_valid;
    logic [N+LV-1:0] out_sum;
    int total = 0;
    int bad = 0;
    logic go = 1'b0;
    int ev = 0;
    int es = 0;
    typedef struct {
        int s;
        int age;
    } beat_t;
    beat_t q[$];
    beat_t nq[$];
    adder_tree_pipe #(.N(N), .NUM_INPUTS(NI)) dut (
        .clk(clk), .reset(reset), .stall(stall), .in_valid(in_valid),
        .in_data(in_data), .out_valid(out_valid), .out_sum(out_sum)
    );
    always #5 clk = ~clk;
    function automatic void chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction
    function automatic int bsum(input logic [NI*N-1:0] d);
        int t = 0;
        for (int k = 0; k < NI; k++) t += int'(d[k*N +: N]);
        return t;
    endfunction
    function automatic logic [NI*N-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        logic [NI*N-1:0] d;
        d[0*N +: N] = N'(a0); d[1*N +: N] = N'(a1); d[2*N +: N] = N'(a2); d[3*N +: N] = N'(a3);
        d[4*N +: N] = N'(a4); d[5*N +: N] = N'(a5); d[6*N +: N] = N'(a6); d[7*N +: N] = N'(a7);
        return d;
    endfunction
    function automatic logic [NI*N-1:0] rnd();
        logic [NI*N-1:0] d;
        for (int k = 0; k < NI; k++) d[k*N +: N] = N'($urandom);
        return d;
    endfunction
    // Model: each accepted beat ages one step per unstalled edge and is at the output at age LV.
    task automatic step(input logic r, input logic s, input logic v, input logic [NI*N-1:0] d);
        int pev, pes;
        reset = r; stall = s; in_valid = v; in_data = d;
        pev = ev; pes = es;
        if (r) begin
            q.delete(); pev = 0; pes = 0;
        end else if (!s) begin
            nq.delete();
            foreach (q[k]) if (q[k].age < LV) nq.push_back('{q[k].s, q[k].age + 1});
            if (v) nq.push_back('{bsum(d), 1});
            q = nq;
            pev = 0;
            foreach (q[k]) if (q[k].age == LV) begin pev = 1; pes = q[k].s; end
        end
        @(posedge clk);
        ev = pev; es = pes;
        if (r) go = 1'b1;
        #1;
    endtask
    task automatic expect_out(input string name, input int v, input int s);
        chk({name, ".valid"}, int'(out_valid), v);
        chk({name, ".sum"}, int'(out_sum), s);
    endtask
    always @(negedge clk) if (go) begin
        chk("model.valid", int'(out_valid), ev);
        chk("model.sum", int'(out_sum), es);
    end
    initial begin
        logic [NI*N-1:0] a8, ones, zer, mix;
        a8 = pk(1, 2, 3, 4, 5, 6, 7, 8);
        ones = pk(1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023);
        zer = '0;
        mix = pk(1, 99, 33, 66, 100, 47, 0, 0);
        chk("lit.bsum36", bsum(a8), 36);
        chk("lit.bsum8184", bsum(ones), 8184);
        chk("lit.bsum346", bsum(mix), 346);
        step(1, 0, 1, rnd()); expect_out("rst0", 0, 0);
        step(1, 0, 1, rnd()); expect_out("rst1", 0, 0);
        for (int k = 0; k < 3; k++) begin step(0, 0, 0, rnd()); expect_out("idle", 0, 0); end
        step(0, 0, 1, a8);    expect_out("one.t0", 0, 0);
        step(0, 0, 0, rnd()); expect_out("one.t1", 0, 0);
        step(0, 0, 0, rnd()); expect_out("one.t2", 1, 36);
        step(0, 0, 0, rnd()); expect_out("one.t3", 0, 36);
        step(0, 0, 1, ones);  step(0, 0, 1, zer);
        step(0, 0, 1, mix);   expect_out("b2b.a", 1, 8184);
        step(0, 0, 0, rnd()); expect_out("b2b.b", 1, 0);
        step(0, 0, 0, rnd()); expect_out("b2b.c", 1, 346);
        step(0, 0, 0, rnd()); expect_out("b2b.end", 0, 346);
        step(0, 0, 1, a8);    step(0, 0, 1, mix);
        step(0, 1, 1, ones);  expect_out("stl.s0", 0, 346);
        step(0, 1, 1, ones);  expect_out("stl.s1", 0, 346);
        step(0, 0, 0, rnd()); expect_out("stl.a", 1, 36);
        step(0, 1, 0, rnd()); expect_out("stl.hold", 1, 36);
        step(0, 0, 0, rnd()); expect_out("stl.b", 1, 346);
        step(0, 0, 0, rnd()); expect_out("stl.end", 0, 346);
        step(0, 0, 1, a8);    step(0, 0, 0, rnd());
        step(0, 0, 1, ones);  expect_out("bub.a", 1, 36);
        step(0, 0, 0, rnd()); expect_out("bub.gap", 0, 36);
        step(0, 0, 0, rnd()); expect_out("bub.c", 1, 8184);
        step(0, 0, 1, a8);    step(0, 0, 1, mix);
        step(1, 0, 0, rnd()); expect_out("mrst.r", 0, 0);
        for (int k = 0; k < 4; k++) begin step(0, 0, 0, rnd()); expect_out("mrst.idle", 0, 0); end
        step(0, 0, 1, a8);    expect_out("mrst.t0", 0, 0);
        step(0, 0, 0, rnd()); expect_out("mrst.t1", 0, 0);
        step(0, 0, 0, rnd()); expect_out("mrst.t2", 1, 36);
        for (int k = 0; k < 2000; k++)
            step(logic'($urandom_range(49) == 0), logic'($urandom_range(3) == 0),
                 logic'($urandom_range(1)), ($urandom_range(7) == 0) ? ones : rnd());
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
